avg_pool_compute_stage: RTL and testbench
=========================================

# avg_pool_compute_stage

Compute stage between `hw_input_stencil_ub` and `avg_pool_stencil_clkwrk_dsa0_ub` in the down_sample pipeline. It drives the loop nest `(c, y, x)` over the 32x32x4 output and issues the 4-tap read to the input buffer, whose read data is combinational. It averages each 2x2 window and writes the result, with its control vars, to the avg-pool buffer one cycle later. A start/done handshake and an upstream-availability stall gate the sweep.

## Interface

**Parameters**
- `W`, default 16: data width.
- `OUT_W`, default 32: output columns (x extent).
- `OUT_H`, default 32: output rows (y extent).
- `CH`, default 4: channels (c extent).
- `ROUND`, default 0: 0 = truncate; 1 = round-half-up (add 2 before the shift).

**Ports**
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous abort to IDLE.
- `start` input 1: one-cycle pulse; begins a sweep when IDLE.
- `in_avail` input 1: upstream data ready for the current window. Low stalls read issue.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: one-cycle pulse after the final write.
- `rd_ren` output 1: read enable to the input buffer.
- `rd_ctrl_vars` output 4x16: `[0]`=0, `[1]`=c, `[2]`=y, `[3]`=x.
- `rd_data` input 4xW: window taps from the input buffer, valid in the same cycle as `rd_ren`.
- `wr_wen` output 1: write enable to the avg-pool buffer.
- `wr_ctrl_vars` output 4x16: the registered copy of the `rd_ctrl_vars` that produced this result.
- `wr_data` output W: averaged value.

## Operation

**FSM states**
- IDLE
  - Counters are zero.
  - `start` moves to RUN. `start` in any other state is ignored.
- RUN
  - In each cycle with `in_avail`=1: drive `rd_ren`=1 with the current (c, y, x), capture the result, then advance the counters.
  - Counter order: x increments; when x hits OUT_W-1 it wraps to 0 and y increments; when y hits OUT_H-1 it wraps to 0 and c increments.
  - After issuing (CH-1, OUT_H-1, OUT_W-1), move to DRAIN.
  - With `in_avail`=0: `rd_ren`=0 and counters hold.
- DRAIN
  - Lasts one cycle, in which the final write is emitted.
  - Then go to IDLE, pulse `done`, and reset the counters.

**Arithmetic**
- `sum` is W+2 bits, unsigned: `rd_data[0]+[1]+[2]+[3]`, plus 2 when ROUND=1.
- `wr_data = sum[W+1:2]`. No saturation is needed, because the maximum value fits.

**Control vars**
- `rd_ctrl_vars` is combinational from the counters. It holds the current counter value even when `rd_ren`=0.
- Tap address mapping (performed by the input buffer, not by this block) is `2x+dx, 2y+dy, c`.

**Flush**
- Returns to IDLE and zeroes the counters.
- Clears the pending write: `wr_wen`=0 next cycle.
- No `done` is produced.

**Reset**
- All outputs are 0 and the FSM is in IDLE, including when reset asserts mid-sweep. Partial results are discarded.

## Timing

- Read to write: a read issued with `rd_ren` at cycle t produces `wr_wen`=1 at cycle t+1, with the registered `wr_ctrl_vars` and `wr_data`. The downstream RAM commits at the end of t+1.
- Throughput: 1 window per cycle while `in_avail`=1. Stalls insert `wr_wen`=0 bubbles with no loss or duplication.
- Write count: exactly OUT_W·OUT_H·CH `wr_wen` pulses per sweep (4096 by default).
- Minimum sweep length: 1 + 4096 + 1 cycles from `start`, with `done` in the cycle after DRAIN.
- `start` in the `done` cycle: accepted, since the FSM is already IDLE.
- `busy` timing: high from the cycle after `start` through DRAIN inclusive.
- Flush precedence: `flush` wins over `start` and `in_avail` in the same cycle.

## Test plan

1. **Single window.** Run with OUT_W=OUT_H=CH=1 and taps 4,8,12,16.
   - At t+1: `wr_wen`=1, `wr_data`=10, `wr_ctrl_vars`={0,0,0,0}.
   - `done` one cycle later.
2. **Rounding.** Taps 1,1,1,2 (sum 5).
   - ROUND=0 gives `wr_data`=1; ROUND=1 gives 1 ((5+2)>>2=1).
   - Taps 1,1,2,2: ROUND=1 gives 2.
   - Taps 0xFFFF×4 gives 0xFFFF with no overflow.
3. **Full sweep, default params, `in_avail` tied high.**
   - Exactly 4096 writes.
   - Ctrl vars follow x fastest, then y, then c.
   - The last write is {0,3,31,31}.
   - `done` arrives 4098 cycles after `start`.
4. **Stall.** Drop `in_avail` for 5 cycles at (c=1, y=7, x=31).
   - No `rd_ren` during the stall; counters hold.
   - The next write after the stall is {0,1,7,31}, then {0,1,8,0}.
   - Total is still 4096 writes.
5. **Flush mid-sweep after 100 reads.**
   - The next cycle has `wr_wen`=0, the FSM is IDLE, and `busy`=0 with no `done`.
   - A new `start` restarts from {0,0,0,0}.
6. **Async reset mid-sweep.**
   - All outputs go to 0 immediately.
   - After release, `start` is ignored while in IDLE until pulsed.
   - `start` asserted during RUN is ignored.

Source files
------------

// File: rtl/avg_pool_compute_stage.sv
// Compute stage of the down_sample pipeline: sweeps (c, y, x) over the output,
// reads the 2x2 window taps and writes their average to the avg-pool buffer.
module avg_pool_compute_stage #(
  parameter int W     = 16,
  parameter int OUT_W = 32,
  parameter int OUT_H = 32,
  parameter int CH    = 4,
  parameter int ROUND = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                start,
  input  logic                in_avail,
  output logic                busy,
  output logic                done,
  output logic                rd_ren,
  output logic [3:0][15:0]    rd_ctrl_vars,
  input  logic [3:0][W-1:0]   rd_data,
  output logic                wr_wen,
  output logic [3:0][15:0]    wr_ctrl_vars,
  output logic [W-1:0]        wr_data,
  output logic [1:0]          state_dbg
);

  // Handshake: there is no backpressure on either side. rd_ren is a valid
  // strobe whose taps come back combinationally in the same cycle; in_avail
  // acts as the upstream ready and only gates issue. wr_wen is a valid strobe
  // the avg-pool buffer must accept in the cycle it is high.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [15:0] X_LAST = 16'(OUT_W - 1);
  localparam logic [15:0] Y_LAST = 16'(OUT_H - 1);
  localparam logic [15:0] C_LAST = 16'(CH - 1);

  localparam logic [W+1:0] RND_BIAS = (ROUND != 0) ? (W+2)'(2) : '0;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [15:0]  x_q;
  logic [15:0]  y_q;
  logic [15:0]  c_q;
  logic         x_wrap;
  logic         y_wrap;
  logic         last_issue;
  logic [W+1:0] sum;

  assign x_wrap     = (x_q == X_LAST);
  assign y_wrap     = (y_q == Y_LAST);
  assign last_issue = x_wrap && y_wrap && (c_q == C_LAST);

  // flush suppresses issue so the pending write is dropped in the same edge.
  assign rd_ren    = (state == S_RUN) && in_avail && !flush;
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign state_dbg = state;

  always_comb begin
    rd_ctrl_vars    = '0;
    rd_ctrl_vars[1] = c_q;
    rd_ctrl_vars[2] = y_q;
    rd_ctrl_vars[3] = x_q;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_RUN;
        S_RUN:   if (rd_ren && last_issue) state_nxt = S_DRAIN;
        S_DRAIN: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= !flush && (state == S_DRAIN);
    end
  end

  // The final issue wraps every counter, so they are already zero in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else if (flush || (state != S_RUN)) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else if (rd_ren) begin
      if (x_wrap) begin
        x_q <= '0;
        if (y_wrap) begin
          y_q <= '0;
          c_q <= (c_q == C_LAST) ? 16'd0 : c_q + 16'd1;
        end else begin
          y_q <= y_q + 16'd1;
        end
      end else begin
        x_q <= x_q + 16'd1;
      end
    end
  end

  // Four W-bit taps plus the bias cannot exceed W+2 bits.
  always_comb begin
    sum = {2'b00, rd_data[0]} + {2'b00, rd_data[1]}
        + {2'b00, rd_data[2]} + {2'b00, rd_data[3]} + RND_BIAS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_wen       <= 1'b0;
      wr_ctrl_vars <= '0;
      wr_data      <= '0;
    end else begin
      wr_wen <= rd_ren;
      if (rd_ren) begin
        wr_ctrl_vars <= rd_ctrl_vars;
        wr_data      <= W'(sum >> 2);
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_compute_stage.sv
// Bench for avg_pool_compute_stage: default-size sweep checked every cycle
// against a window-index model, plus 1x1x1 instances for the arithmetic.
module tb_avg_pool_compute_stage;
  localparam int W  = 16;
  localparam int OW = 32;
  localparam int OH = 32;
  localparam int NC = 4;
  localparam int N  = OW * OH * NC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // main instance
  logic             flush, start, in_avail;
  logic             busy, done, rd_ren, wr_wen;
  logic [3:0][15:0] rd_ctrl, wr_ctrl;
  logic [3:0][W-1:0] rd_data;
  logic [W-1:0]     wr_data;
  logic [1:0]       state_dbg;

  // 1x1x1 instances sharing one stimulus, truncating (a) and rounding (b)
  logic             flush1, start1, in_avail1;
  logic [3:0][W-1:0] rd_data1;
  logic             busy_a, done_a, rd_ren_a, wr_wen_a;
  logic             busy_b, done_b, rd_ren_b, wr_wen_b;
  logic [3:0][15:0] rd_ctrl_a, wr_ctrl_a, rd_ctrl_b, wr_ctrl_b;
  logic [W-1:0]     wr_data_a, wr_data_b;
  logic [1:0]       state_a, state_b;

  avg_pool_compute_stage #(.W(W), .OUT_W(OW), .OUT_H(OH), .CH(NC), .ROUND(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .in_avail(in_avail),
    .busy(busy), .done(done), .rd_ren(rd_ren), .rd_ctrl_vars(rd_ctrl),
    .rd_data(rd_data), .wr_wen(wr_wen), .wr_ctrl_vars(wr_ctrl),
    .wr_data(wr_data), .state_dbg(state_dbg));

  avg_pool_compute_stage #(.W(W), .OUT_W(1), .OUT_H(1), .CH(1), .ROUND(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .start(start1), .in_avail(in_avail1),
    .busy(busy_a), .done(done_a), .rd_ren(rd_ren_a), .rd_ctrl_vars(rd_ctrl_a),
    .rd_data(rd_data1), .wr_wen(wr_wen_a), .wr_ctrl_vars(wr_ctrl_a),
    .wr_data(wr_data_a), .state_dbg(state_a));

  avg_pool_compute_stage #(.W(W), .OUT_W(1), .OUT_H(1), .CH(1), .ROUND(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .start(start1), .in_avail(in_avail1),
    .busy(busy_b), .done(done_b), .rd_ren(rd_ren_b), .rd_ctrl_vars(rd_ctrl_b),
    .rd_data(rd_data1), .wr_wen(wr_wen_b), .wr_ctrl_vars(wr_ctrl_b),
    .wr_data(wr_data_b), .state_dbg(state_b));

  // ---------------- model helpers ----------------
  function automatic int pix(int r, int col, int ch);
    return (r * 1237 + col * 389 + ch * 9001 + 17) % 65536;
  endfunction

  function automatic logic [63:0] mk(int c, int y, int x);
    logic [3:0][15:0] v;
    v[0] = 16'd0;
    v[1] = 16'(c);
    v[2] = 16'(y);
    v[3] = 16'(x);
    return v;
  endfunction

  function automatic logic [63:0] coords(int k);
    return mk(k / (OW * OH), (k / OW) % OH, k % OW);
  endfunction

  function automatic logic [63:0] exp_avg(int k);
    int c, y, x, s;
    c = k / (OW * OH);
    y = (k / OW) % OH;
    x = k % OW;
    s = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        s += pix(2 * y + dy, 2 * x + dx, c);
    return 64'(s / 4);
  endfunction

  // input buffer: combinational taps at (2x+dx, 2y+dy, c)
  always_comb begin
    for (int i = 0; i < 4; i++)
      rd_data[i] = W'(pix(2 * int'(rd_ctrl[2]) + i / 2, 2 * int'(rd_ctrl[3]) + i % 2,
                          int'(rd_ctrl[1])));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_reads = windows issued in this sweep; N issued means the drain cycle.
  bit m_active, m_wv, m_done;
  int m_reads, m_widx;
  logic m_ren;
  assign m_ren = m_active && (m_reads < N) && in_avail && !flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_reads <= 0; m_wv <= 0; m_widx <= 0; m_done <= 0;
    end else if (flush) begin
      m_active <= 0; m_reads <= 0; m_wv <= 0; m_done <= 0;
    end else begin
      m_wv   <= m_ren;
      if (m_ren) m_widx <= m_reads;
      m_done <= m_active && (m_reads == N);
      if (m_active && (m_reads == N)) begin
        m_active <= 0;
        m_reads  <= 0;
      end else if (m_ren) begin
        m_reads <= m_reads + 1;
      end else if (!m_active && start) begin
        m_active <= 1;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy", busy, m_active);
      chk("rd_ren", rd_ren, m_ren);
      chk("rd_ctrl", rd_ctrl, coords(m_reads % N));
      chk("wr_wen", wr_wen, m_wv);
      chk("done", done, m_done);
      if (m_wv) begin
        chk("wr_ctrl", wr_ctrl, coords(m_widx));
        chk("wr_data", wr_data, exp_avg(m_widx));
      end
    end
  end

  int wr_cnt = 0;
  logic [63:0] last_wr = '0;
  always @(negedge clk) begin
    if (rst_n && wr_wen) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= wr_ctrl;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk); #1 start = 1'b1; s = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic small_run(input logic [63:0] taps, input logic [W-1:0] e_t,
                           input logic [W-1:0] e_r, input string nm);
    @(posedge clk); #1 rd_data1 = taps; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk({nm, "_rd_ren"}, rd_ren_a, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_wr_wen"}, wr_wen_a, 1);
    chk({nm, "_trunc"}, wr_data_a, e_t);
    chk({nm, "_round"}, wr_data_b, e_r);
    chk({nm, "_wr_ctrl"}, wr_ctrl_a, 0);
    chk({nm, "_early_done"}, done_a, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_done_a"}, done_a, 1);
    chk({nm, "_done_b"}, done_b, 1);
    chk({nm, "_busy_after"}, busy_a, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, dc, base;
    bit got;
    flush = 0; start = 0; in_avail = 1;
    flush1 = 0; start1 = 0; in_avail1 = 1; rd_data1 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_ren", rd_ren, 0);
    chk("rst_rd_ctrl", rd_ctrl, 0);
    chk("rst_wr_wen", wr_wen, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    // arithmetic on 1x1x1 instances: taps listed [3]..[0]
    small_run({16'd16, 16'd12, 16'd8, 16'd4}, 16'd10, 16'd10, "win");
    small_run({16'd2, 16'd1, 16'd1, 16'd1}, 16'd1, 16'd1, "sum5");
    small_run({16'd2, 16'd2, 16'd1, 16'd1}, 16'd1, 16'd2, "sum6");
    small_run({4{16'hFFFF}}, 16'hFFFF, 16'hFFFF, "max");

    // full sweep, in_avail high
    base = wr_cnt;
    pulse_start(s);
    wait_done(5000, dc);
    chk("sweep_latency", dc - s, 4098);
    chk("sweep_writes", wr_cnt - base, N);
    chk("sweep_last", last_wr, mk(3, 31, 31));

    // 5-cycle stall on window (1,7,31)
    base = wr_cnt;
    pulse_start(s);
    repeat (1279) @(posedge clk);
    #1 in_avail = 1'b0;
    @(negedge clk);
    chk("stall_rd_ren", rd_ren, 0);
    chk("stall_ctrl", rd_ctrl, mk(1, 7, 31));
    repeat (5) @(posedge clk);
    #1 in_avail = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_stall_wen", wr_wen, 1);
    chk("post_stall_w0", wr_ctrl, mk(1, 7, 31));
    @(negedge clk);
    chk("post_stall_w1", wr_ctrl, mk(1, 8, 0));
    wait_done(5000, dc);
    chk("stall_latency", dc - s, 4098 + 5);
    chk("stall_writes", wr_cnt - base, N);

    // flush after 100 reads
    pulse_start(s);
    repeat (100) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_wr_wen", wr_wen, 0);
    chk("flush_state", state_dbg, 0);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    repeat (3) @(negedge clk);
    chk("flush_no_done", done, 0);

    // flush beats start in the same cycle
    @(posedge clk); #1 start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_vs_start", busy, 0);

    // restart from origin, then async reset mid-sweep
    pulse_start(s);
    @(negedge clk);
    chk("restart_ctrl", rd_ctrl, mk(0, 0, 0));
    @(negedge clk);
    chk("restart_wr", wr_ctrl, mk(0, 0, 0));
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd_ren", rd_ren, 0);
    chk("arst_rd_ctrl", rd_ctrl, 0);
    chk("arst_wr_wen", wr_wen, 0);
    chk("arst_wr_ctrl", wr_ctrl, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_state", state_dbg, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_rst", busy, 0);

    // patterned stalls, with start re-pulsed during RUN
    base = wr_cnt;
    pulse_start(s);
    got = 0;
    for (int k = 0; k < 7000; k++) begin
      @(posedge clk); #1;
      in_avail = ((cyc % 7) != 3) && ((cyc % 11) != 5);
      start = (k == 30 || k == 31);
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    in_avail = 1'b1;
    start = 1'b0;
    chk("pattern_done", got, 1);
    chk("pattern_writes", wr_cnt - base, N);
    chk("pattern_last", last_wr, mk(3, 31, 31));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
